// File: rtl/device_arbiter_rr_pkg.sv
// Shared types and constants for the round-robin device arbiter.
// The watchdog feature is selected by the ARB_TIMEOUT_EN macro in device_arbiter_rr.
package device_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    localparam logic [7:0] UART_TAG_DEFAULT = 8'hC0;

    // Every bit of the read data is driven to this value on a watchdog abort.
    localparam logic ABORT_FILL = 1'b1;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/device_arbiter_rr_if.sv
// Core-side and device-side bus of the device arbiter; master is the arbiter's view,
// slave is the view of the cores plus the device they share.
interface device_arbiter_rr_if #(
    parameter int XLEN      = 32,
    parameter int CORE_NUMS = 4
);
    logic [CORE_NUMS-1:0]          P_DEVICE_strobe_i;
    logic [CORE_NUMS*XLEN-1:0]     P_DEVICE_addr_i;
    logic [CORE_NUMS-1:0]          P_DEVICE_rw_i;
    logic [CORE_NUMS*XLEN/8-1:0]   P_DEVICE_byte_enable_i;
    logic [CORE_NUMS*XLEN-1:0]     P_DEVICE_data_i;
    logic [CORE_NUMS-1:0]          P_DEVICE_data_ready_o;
    logic [XLEN-1:0]               P_DEVICE_data_o;

    logic                          DEVICE_strobe_o;
    logic [XLEN-1:0]               DEVICE_addr_o;
    logic                          DEVICE_rw_o;
    logic [XLEN/8-1:0]             DEVICE_byte_enable_o;
    logic [XLEN-1:0]               DEVICE_data_o;
    logic                          DEVICE_data_ready_i;
    logic [XLEN-1:0]               DEVICE_data_i;

    modport master (
        input  P_DEVICE_strobe_i, P_DEVICE_addr_i, P_DEVICE_rw_i,
               P_DEVICE_byte_enable_i, P_DEVICE_data_i,
               DEVICE_data_ready_i, DEVICE_data_i,
        output P_DEVICE_data_ready_o, P_DEVICE_data_o,
               DEVICE_strobe_o, DEVICE_addr_o, DEVICE_rw_o,
               DEVICE_byte_enable_o, DEVICE_data_o
    );

    modport slave (
        output P_DEVICE_strobe_i, P_DEVICE_addr_i, P_DEVICE_rw_i,
               P_DEVICE_byte_enable_i, P_DEVICE_data_i,
               DEVICE_data_ready_i, DEVICE_data_i,
        input  P_DEVICE_data_ready_o, P_DEVICE_data_o,
               DEVICE_strobe_o, DEVICE_addr_o, DEVICE_rw_o,
               DEVICE_byte_enable_o, DEVICE_data_o
    );

endinterface

// File: rtl/device_arbiter_rr_rr_pick.sv
// Rotating priority encoder: first set bit of req scanning last+1, last+2, ... modulo CORE_NUMS.
// Purely combinational; shared with the memory arbiter.
module rr_pick
    import device_arb_pkg::*;
#(
    parameter int CORE_NUMS      = 4,
    parameter int CORE_NUMS_BITS = idx_bits(CORE_NUMS)
) (
    input  logic [CORE_NUMS-1:0]      req,
    input  logic [CORE_NUMS_BITS-1:0] last,
    output logic [CORE_NUMS_BITS-1:0] idx,
    output logic                      valid
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves it unassigned
        // and no latch is inferred.
        idx   = '0;
        valid = 1'b0;
        for (int k = 1; k <= CORE_NUMS; k++) begin
            if (!valid && req[(int'(last) + k) % CORE_NUMS]) begin
                valid = 1'b1;
                idx   = CORE_NUMS_BITS'((int'(last) + k) % CORE_NUMS);
            end
        end
    end

endmodule

// File: rtl/device_arbiter_rr.sv
// N-core to single device-slave arbiter with round-robin grant and UART ownership tracking.
// Define ARB_TIMEOUT_EN to build the watchdog that aborts hung device transactions.
module device_arbiter_rr
    import device_arb_pkg::*;
#(
    parameter int         XLEN           = 32,
    parameter int         CORE_NUMS      = 4,
    parameter int         CORE_NUMS_BITS = idx_bits(CORE_NUMS),
    parameter logic [7:0] UART_TAG       = UART_TAG_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    device_arbiter_rr_if.master       bus,
    output logic [CORE_NUMS_BITS-1:0] uart_core_sel_o,
    output logic [CORE_NUMS_BITS-1:0] grant_o,
    output logic                      timeout_o
);

    localparam int BE_W = XLEN / 8;

    arb_state_e                state_q, state_d;
    logic [CORE_NUMS_BITS-1:0] grant_q, grant_d;
    logic [CORE_NUMS_BITS-1:0] last_grant_q, last_grant_d;
    logic [CORE_NUMS_BITS-1:0] uart_sel_q, uart_sel_d;
    logic [CORE_NUMS-1:0]      pend_q, pend_d;
    logic [CORE_NUMS-1:0]      rw_cap_q, rw_cap_d;
    logic [XLEN-1:0]           addr_cap_q [CORE_NUMS];
    logic [XLEN-1:0]           addr_cap_d [CORE_NUMS];
    logic [XLEN-1:0]           data_cap_q [CORE_NUMS];
    logic [XLEN-1:0]           data_cap_d [CORE_NUMS];
    logic [BE_W-1:0]           be_cap_q   [CORE_NUMS];
    logic [BE_W-1:0]           be_cap_d   [CORE_NUMS];

    logic                      dev_strobe_q, dev_strobe_d;
    logic                      dev_rw_q, dev_rw_d;
    logic [XLEN-1:0]           dev_addr_q, dev_addr_d;
    logic [XLEN-1:0]           dev_data_q, dev_data_d;
    logic [BE_W-1:0]           dev_be_q, dev_be_d;

    logic [CORE_NUMS_BITS-1:0] pick_idx;
    logic                      pick_valid;
    logic                      timeout_hit;
    logic                      done;
    logic                      abort;
    logic [CORE_NUMS-1:0]      ready_vec;

    rr_pick #(
        .CORE_NUMS      (CORE_NUMS),
        .CORE_NUMS_BITS (CORE_NUMS_BITS)
    ) u_pick (
        .req   (pend_q),
        .last  (last_grant_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == ST_ISSUE)     wd_cnt_d = '0;
        else if (state_q == ST_WAIT) wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) wd_cnt_q <= '0;
        else         wd_cnt_q <= wd_cnt_d;
    end

    assign timeout_hit = (state_q == ST_WAIT) && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // A real slave ready in the same cycle as the watchdog limit is a normal completion.
    assign done  = (state_q == ST_WAIT) && (bus.DEVICE_data_ready_i || timeout_hit);
    assign abort = timeout_hit && !bus.DEVICE_data_ready_i;

    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < CORE_NUMS; i++) begin
            ready_vec[i] = done && (grant_q == CORE_NUMS_BITS'(i));
        end
    end

    // Strobe capture; the granted core's fields stay frozen until it completes.
    always_comb begin
        pend_d   = (pend_q & ~ready_vec) | bus.P_DEVICE_strobe_i;
        rw_cap_d = rw_cap_q;
        for (int i = 0; i < CORE_NUMS; i++) begin
            addr_cap_d[i] = addr_cap_q[i];
            data_cap_d[i] = data_cap_q[i];
            be_cap_d[i]   = be_cap_q[i];
            if (bus.P_DEVICE_strobe_i[i] &&
                !((state_q != ST_IDLE) && (grant_q == CORE_NUMS_BITS'(i)))) begin
                addr_cap_d[i] = bus.P_DEVICE_addr_i[i*XLEN +: XLEN];
                data_cap_d[i] = bus.P_DEVICE_data_i[i*XLEN +: XLEN];
                be_cap_d[i]   = bus.P_DEVICE_byte_enable_i[i*BE_W +: BE_W];
                rw_cap_d[i]   = bus.P_DEVICE_rw_i[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        uart_sel_d   = uart_sel_q;
        dev_strobe_d = 1'b0;
        dev_addr_d   = dev_addr_q;
        dev_data_d   = dev_data_q;
        dev_be_d     = dev_be_q;
        dev_rw_d     = dev_rw_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d      = ST_ISSUE;
                    grant_d      = pick_idx;
                    dev_strobe_d = 1'b1;
                    dev_addr_d   = addr_cap_d[pick_idx];
                    dev_data_d   = data_cap_d[pick_idx];
                    dev_be_d     = be_cap_d[pick_idx];
                    dev_rw_d     = rw_cap_d[pick_idx];
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                if (dev_addr_q[XLEN-1 -: 8] == UART_TAG) uart_sel_d = grant_q;
            end
            ST_WAIT: begin
                if (done) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= '0;
            uart_sel_q   <= '0;
            pend_q       <= '0;
            rw_cap_q     <= '0;
            dev_strobe_q <= 1'b0;
            dev_addr_q   <= '0;
            dev_data_q   <= '0;
            dev_be_q     <= '0;
            dev_rw_q     <= 1'b0;
            // NOTE: the capture arrays are per-core flops, not RAM, so resetting them is cheap
            // and keeps the device outputs deterministic after reset.
            for (int i = 0; i < CORE_NUMS; i++) begin
                addr_cap_q[i] <= '0;
                data_cap_q[i] <= '0;
                be_cap_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            uart_sel_q   <= uart_sel_d;
            pend_q       <= pend_d;
            rw_cap_q     <= rw_cap_d;
            dev_strobe_q <= dev_strobe_d;
            dev_addr_q   <= dev_addr_d;
            dev_data_q   <= dev_data_d;
            dev_be_q     <= dev_be_d;
            dev_rw_q     <= dev_rw_d;
            for (int i = 0; i < CORE_NUMS; i++) begin
                addr_cap_q[i] <= addr_cap_d[i];
                data_cap_q[i] <= data_cap_d[i];
                be_cap_q[i]   <= be_cap_d[i];
            end
        end
    end

    assign bus.P_DEVICE_data_ready_o = ready_vec;
    assign bus.P_DEVICE_data_o       = abort ? {XLEN{ABORT_FILL}} : bus.DEVICE_data_i;
    assign bus.DEVICE_strobe_o       = dev_strobe_q;
    assign bus.DEVICE_addr_o         = dev_addr_q;
    assign bus.DEVICE_rw_o           = dev_rw_q;
    assign bus.DEVICE_byte_enable_o  = dev_be_q;
    assign bus.DEVICE_data_o         = dev_data_q;
    assign uart_core_sel_o           = uart_sel_q;
    assign grant_o                   = grant_q;
    assign timeout_o                 = abort;

endmodule

// File: tb/tb_device_arbiter_rr.sv
// Directed bench for device_arbiter_rr (4 cores, watchdog limit 16 when ARB_TIMEOUT_EN is set).
module tb_device_arbiter_rr;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [1:0] uart_core_sel_o;
    logic [1:0] grant_o;
    logic       timeout_o;

    int n_vec = 0;
    int n_bad = 0;

    device_arbiter_rr_if #(.XLEN(32), .CORE_NUMS(4)) bus ();

    device_arbiter_rr #(
        .XLEN           (32),
        .CORE_NUMS      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .bus             (bus),
        .uart_core_sel_o (uart_core_sel_o),
        .grant_o         (grant_o),
        .timeout_o       (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          core;
        logic        rw;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic [3:0]  exp_mask;
        logic [1:0]  exp_uart;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int core, input logic rw, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
        bus.P_DEVICE_strobe_i[core]             = 1'b1;
        bus.P_DEVICE_rw_i[core]                 = rw;
        bus.P_DEVICE_addr_i[core*32 +: 32]      = addr;
        bus.P_DEVICE_byte_enable_i[core*4 +: 4] = be;
        bus.P_DEVICE_data_i[core*32 +: 32]      = wdata;
    endtask

    task automatic send(input int core, input logic rw, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata);
        set_req(core, rw, addr, be, wdata);
        tick();
        bus.P_DEVICE_strobe_i = '0;
    endtask

    // Called one cycle after a strobe or a ready; returns the extra cycles until DEVICE_strobe_o.
    task automatic wait_issue(output int n);
        n = 0;
        while (!bus.DEVICE_strobe_o && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic complete(input int delay, input logic [31:0] rdata, input logic [3:0] mask);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("ready_before_slave", bus.P_DEVICE_data_ready_o, 4'b0000);
        end
        bus.DEVICE_data_i       = rdata;
        bus.DEVICE_data_ready_i = 1'b1;
        #1;
        check("ready_mask", bus.P_DEVICE_data_ready_o, mask);
        check("read_data", bus.P_DEVICE_data_o, rdata);
        check("timeout_on_ready", timeout_o, 1'b0);
        tick();
        bus.DEVICE_data_ready_i = 1'b0;
    endtask

    task automatic do_txn(input vec_t v);
        int n;
        send(v.core, v.rw, v.addr, v.be, v.wdata);
        wait_issue(n);
        check("issue_latency", 1 + n, 2);
        check("addr_o", bus.DEVICE_addr_o, v.addr);
        check("rw_o", bus.DEVICE_rw_o, v.rw);
        check("be_o", bus.DEVICE_byte_enable_o, v.be);
        check("wdata_o", bus.DEVICE_data_o, v.wdata);
        check("grant_o", grant_o, v.core);
        complete(v.delay, v.rdata, v.exp_mask);
        check("uart_sel", uart_core_sel_o, v.exp_uart);
    endtask

    initial begin
        int n;
        int order[4];
        logic bad;

        vecs[0] = '{2, 1'b0, 32'h8000_0010, 4'hF,    32'h0000_0000, 32'h1234_5678, 2, 4'b0100, 2'd0};
        vecs[1] = '{3, 1'b1, 32'hC000_0004, 4'b0011, 32'hA5A5_0001, 32'h0000_0000, 1, 4'b1000, 2'd3};
        vecs[2] = '{1, 1'b1, 32'h8000_0000, 4'hF,    32'h0000_BEEF, 32'h0000_0001, 3, 4'b0010, 2'd3};
        vecs[3] = '{0, 1'b0, 32'hC000_0100, 4'hF,    32'h0000_0000, 32'hDEAD_BEEF, 1, 4'b0001, 2'd0};
        vecs[4] = '{1, 1'b0, 32'hC0FF_FFFC, 4'hF,    32'h0000_0000, 32'h0000_0000, 4, 4'b0010, 2'd1};
        vecs[5] = '{2, 1'b1, 32'h7FFF_FFFF, 4'b1000, 32'h8765_4321, 32'hFFFF_0000, 2, 4'b0100, 2'd1};

        bus.P_DEVICE_strobe_i      = '0;
        bus.P_DEVICE_addr_i        = '0;
        bus.P_DEVICE_rw_i          = '0;
        bus.P_DEVICE_byte_enable_i = '0;
        bus.P_DEVICE_data_i        = '0;
        bus.DEVICE_data_ready_i    = 1'b0;
        bus.DEVICE_data_i          = '0;

        // Reset and idle.
        repeat (3) tick();
        check("rst_strobe_o", bus.DEVICE_strobe_o, 1'b0);
        check("rst_addr_o", bus.DEVICE_addr_o, 32'h0);
        check("rst_ready_o", bus.P_DEVICE_data_ready_o, 4'b0000);
        check("rst_grant", grant_o, 2'd0);
        check("rst_uart_sel", uart_core_sel_o, 2'd0);
        check("rst_timeout", timeout_o, 1'b0);
        rst_ni = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            tick();
            bad |= bus.DEVICE_strobe_o;
        end
        check("idle_no_strobe", bad, 1'b0);
        bus.DEVICE_data_i = 32'hCAFE_0001;
        #1;
        check("data_broadcast", bus.P_DEVICE_data_o, 32'hCAFE_0001);

        // Single transactions from the table.
        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i]);
            tick();
        end

        // Round-robin with last_grant=0 and all cores pending at once.
        do_txn('{0, 1'b0, 32'h8000_0020, 4'hF, 32'h0, 32'h0000_0020, 1, 4'b0001, 2'd1});
        for (int c = 0; c < 4; c++) set_req(c, 1'b0, 32'h8000_0100 + 32'(c * 4), 4'hF, 32'h0);
        tick();
        bus.P_DEVICE_strobe_i = '0;
        order = '{1, 2, 3, 0};
        for (int k = 0; k < 4; k++) begin
            wait_issue(n);
            check("rr_gap", 1 + n, 2);
            check("rr_grant", grant_o, order[k]);
            check("rr_addr", bus.DEVICE_addr_o, 32'h8000_0100 + 32'(order[k] * 4));
            complete(2, 32'h0000_0100 + 32'(k), 4'(1 << order[k]));
        end
        check("rr_uart_sel", uart_core_sel_o, 2'd1);

        // Slave ready outside WAIT is ignored.
        bus.DEVICE_data_ready_i = 1'b1;
        #1;
        check("idle_ready_ignored", bus.P_DEVICE_data_ready_o, 4'b0000);
        tick();
        bus.DEVICE_data_ready_i = 1'b0;
        check("idle_no_issue", bus.DEVICE_strobe_o, 1'b0);

        // Core 0 strobes while core 1 waits; it is served next with its own fields.
        send(1, 1'b0, 32'h8000_0040, 4'hF, 32'h0);
        wait_issue(n);
        check("miss_grant1", grant_o, 2'd1);
        tick();
        set_req(0, 1'b1, 32'h8000_0A00, 4'b0110, 32'h0BAD_F00D);
        tick();
        bus.P_DEVICE_strobe_i = '0;
        check("miss_no_early_ready", bus.P_DEVICE_data_ready_o, 4'b0000);
        check("miss_addr_held", bus.DEVICE_addr_o, 32'h8000_0040);
        tick();
        complete(0, 32'h4444_0000, 4'b0010);
        wait_issue(n);
        check("miss_gap", 1 + n, 2);
        check("miss_grant0", grant_o, 2'd0);
        check("miss_addr0", bus.DEVICE_addr_o, 32'h8000_0A00);
        check("miss_rw0", bus.DEVICE_rw_o, 1'b1);
        check("miss_be0", bus.DEVICE_byte_enable_o, 4'b0110);
        check("miss_wdata0", bus.DEVICE_data_o, 32'h0BAD_F00D);
        complete(1, 32'h5555_0000, 4'b0001);

`ifdef ARB_TIMEOUT_EN
        // Slave never answers core 2; the watchdog aborts, then core 3 is granted.
        set_req(2, 1'b0, 32'h8000_0050, 4'hF, 32'h0);
        set_req(3, 1'b0, 32'h8000_0060, 4'hF, 32'h0);
        tick();
        bus.P_DEVICE_strobe_i = '0;
        wait_issue(n);
        check("to_grant2", grant_o, 2'd2);
        bus.DEVICE_data_i = 32'h1111_2222;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.P_DEVICE_data_ready_o == 4'b0000 && n < 40);
        check("to_cycles", n, 16);
        check("to_mask", bus.P_DEVICE_data_ready_o, 4'b0100);
        check("to_pulse", timeout_o, 1'b1);
        check("to_data", bus.P_DEVICE_data_o, 32'hFFFF_FFFF);
        tick();
        check("to_pulse_end", timeout_o, 1'b0);
        check("to_data_end", bus.P_DEVICE_data_o, 32'h1111_2222);
        wait_issue(n);
        check("to_next_grant", grant_o, 2'd3);
        complete(1, 32'h6666_0000, 4'b1000);
`else
        // Without the watchdog a silent slave simply stalls the arbiter.
        send(2, 1'b0, 32'h8000_0050, 4'hF, 32'h0);
        wait_issue(n);
        bad = 1'b0;
        repeat (40) begin
            tick();
            bad |= timeout_o | (|bus.P_DEVICE_data_ready_o);
        end
        check("no_watchdog", bad, 1'b0);
        complete(0, 32'h6666_0000, 4'b0100);
`endif

        // Reset during WAIT abandons the transaction without a ready pulse.
        tick();
        send(1, 1'b0, 32'hC000_0010, 4'hF, 32'h0);
        wait_issue(n);
        tick();
        check("mid_uart_sel", uart_core_sel_o, 2'd1);
        rst_ni = 1'b0;
        tick();
        check("mid_rst_grant", grant_o, 2'd0);
        check("mid_rst_uart", uart_core_sel_o, 2'd0);
        check("mid_rst_addr", bus.DEVICE_addr_o, 32'h0);
        rst_ni = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            tick();
            bad |= bus.DEVICE_strobe_o | (|bus.P_DEVICE_data_ready_o);
        end
        check("mid_rst_quiet", bad, 1'b0);
        do_txn('{3, 1'b1, 32'hC000_0008, 4'hF, 32'h0000_0077, 32'h0, 2, 4'b1000, 2'd3});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule

// File: doc/device_arbiter_rr.md
Name: device_arbiter_rr

Overview:
- Parametrised N-core to single-device-slave arbiter with fair round-robin grant. Successor of the fixed-priority device arbiter.
- Sits between the per-core device ports (MMIO region, UART at 0xC0xx_xxxx) and the shared device bus.
- Captures every core strobe so a request issued while the bus is busy is never lost.
- Tracks which core owns the UART for the console mux.
- Optionally aborts hung transactions with a watchdog.

Parameters:
- XLEN, 32, data/address width.
- CORE_NUMS, 4, number of requesting cores, 1..16.
- CORE_NUMS_BITS, $clog2(CORE_NUMS) (min 1), grant index width.
- UART_TAG, 8'hC0, value of addr[XLEN-1:XLEN-8] identifying the UART.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, synchronous, active-low
- P_DEVICE_strobe_i  in  CORE_NUMS  one-cycle request pulse per core
- P_DEVICE_addr_i  in  CORE_NUMS*XLEN  packed; core i occupies [i*XLEN +: XLEN]
- P_DEVICE_rw_i  in  CORE_NUMS  1 = write
- P_DEVICE_byte_enable_i  in  CORE_NUMS*XLEN/8  packed byte enables
- P_DEVICE_data_i  in  CORE_NUMS*XLEN  packed write data
- P_DEVICE_data_ready_o  out  CORE_NUMS  one-hot completion pulse
- P_DEVICE_data_o  out  XLEN  read data, broadcast to all cores
- DEVICE_strobe_o  out  1  one-cycle request to slave
- DEVICE_addr_o  out  XLEN  granted request address
- DEVICE_rw_o  out  1  granted request direction
- DEVICE_byte_enable_o  out  XLEN/8  granted request byte enables
- DEVICE_data_o  out  XLEN  granted request write data
- DEVICE_data_ready_i  in  1  slave completion
- DEVICE_data_i  in  XLEN  slave read data
- uart_core_sel_o  out  CORE_NUMS_BITS  core that last accessed the UART
- grant_o  out  CORE_NUMS_BITS  current or last grant index (debug)
- timeout_o  out  1  watchdog abort pulse; tied to 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - State IDLE.
  - All pend, captured fields, DEVICE_* outputs, uart_core_sel_o, grant_o, timeout_o and last_grant are 0.
  - Reset mid-transaction abandons the transaction silently; no ready pulse is generated.
- Capture, per core i:
  - strobe_i sets pend[i] and latches addr/rw/be/data.
  - P_DEVICE_data_ready_o[i] clears pend[i].
  - If set and clear happen in the same cycle, set wins.
  - While core i is granted (state != IDLE and grant==i), its captured fields are frozen. A re-strobe only sets pend, and the new fields are lost. This is a protocol violation; the bench flags it.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any pend, grant <= first pending index scanning last_grant+1, last_grant+2, ... modulo CORE_NUMS, then go to ISSUE. With no pend, stay in IDLE.
  - ISSUE (exactly 1 cycle):
    - DEVICE_strobe_o=1.
    - DEVICE_addr/rw/be/data_o driven from the registered captured fields of grant; these hold stable until the next ISSUE.
    - If captured addr[XLEN-1:XLEN-8]==UART_TAG, uart_core_sel_o <= grant; otherwise uart_core_sel_o holds.
    - Go to WAIT.
  - WAIT: when DEVICE_data_ready_i=1, P_DEVICE_data_ready_o[grant]=DEVICE_data_ready_i (combinational, same cycle), last_grant <= grant, go to IDLE.
  - DEVICE_data_ready_i outside WAIT is ignored.
- P_DEVICE_data_o = DEVICE_data_i, combinational, all cycles.
- Latency:
  - strobe_i at cycle t gives DEVICE_strobe_o at t+2 when idle.
  - Back-to-back grants have 1 IDLE cycle between a ready and the next strobe_o.
- Fairness: with all cores continuously pending, grants rotate 0,1,...,N-1,0. Worst-case wait is N-1 transactions.
- Wrap: last_grant = N-1 scans from 0. For non-power-of-2 N, indices >= N are never selected.
- CORE_NUMS=1: grant is always 0; the FSM is unchanged.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without ready, the arbiter pulses P_DEVICE_data_ready_o[grant] and timeout_o for 1 cycle, drives P_DEVICE_data_o = {XLEN{1'b1}} that cycle, and returns to IDLE.
  - A real ready in the same cycle wins: normal completion, timeout_o=0.
- Disabled: no counter is built, WAIT waits indefinitely, timeout_o=0.

Decomposition:
- Package device_arb_pkg holds:
  - FSM state enum (IDLE/ISSUE/WAIT).
  - Default UART_TAG.
  - Abort-data constant.
- One sub-module, rr_pick: combinational rotating priority encoder.
  - Inputs: req[CORE_NUMS-1:0] and last[CORE_NUMS_BITS-1:0].
  - Outputs: idx and valid.
  - Reusable by the memory arbiter.

Test Plan:
- Reset and idle: hold rst_ni=0 for 3 cycles, release -> all outputs 0, state IDLE, no strobe_o while all strobe_i=0.
- Single read, N=4: core 2 strobes read at 0x8000_0010; slave returns 0x1234_5678 two cycles later -> strobe_o exactly 2 cycles after request, addr_o=0x8000_0010, ready_o=4'b0100, data_o=0x1234_5678.
- Round-robin: cores 0-3 strobe in the same cycle, last_grant=0 -> grant order 1,2,3,0; each core gets exactly one ready pulse.
- UART ownership: core 3 writes 0xC000_0004, then core 1 writes 0x8000_0000 -> uart_core_sel_o=3 after the first ISSUE and stays 3.
- Missed strobe: core 0 strobes while core 1's transaction is in WAIT -> core 0 is served next with its original fields; its ready arrives only after core 1's ready.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): slave never readies -> ready_o[grant] and timeout_o pulse exactly 16 cycles after entering WAIT, data_o=0xFFFF_FFFF, then the next pending core is granted.
